// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, the
// column/row to hex key map, and the single-row detector.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    // Indexed by {col, row}; entry 0 (col0,row0) sits in the lowest nibble.
    localparam logic [15:0][3:0] KEY_MAP = 64'hCDEF_369B_2580_147A;

    function automatic row_hit_t onehot_row_idx(input logic [3:0] rows);
        row_hit_t hit;
        hit.valid = 1'b0;
        hit.idx   = 2'd0;
        case (rows)
            4'b0001: begin hit.valid = 1'b1; hit.idx = 2'd0; end
            4'b0010: begin hit.valid = 1'b1; hit.idx = 2'd1; end
            4'b0100: begin hit.valid = 1'b1; hit.idx = 2'd2; end
            4'b1000: begin hit.valid = 1'b1; hit.idx = 2'd3; end
            default: begin hit.valid = 1'b0; hit.idx = 2'd0; end
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key delivery channel: hex code on a valid/ready handshake plus the
// dropped-key pulse.
interface keypad_scan_ctrl_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overrun,
        output key_ready
    );

endinterface

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// Free-running scan prescaler; tick is registered and high while the count
// sits at TICK_DIV-1.
module scan_tick_gen #(
    parameter int TICK_DIV = 2400
) (
    input  logic clk,
    input  logic nrst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobe, single-key debounce with lockout until
// release, hex key delivery on valid/ready and a two-digit accepted history.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 2400,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int RELEASE_SCANS  = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [3:0]          row_d,
    output logic [3:0]          col_q,
    keypad_scan_ctrl_if.master  kif,
    output logic [3:0]          digit_new,
    output logic [3:0]          digit_old
);

    localparam int MAX_SCANS = (DEBOUNCE_SCANS > RELEASE_SCANS) ? DEBOUNCE_SCANS : RELEASE_SCANS;
    localparam int CNT_W     = $clog2(MAX_SCANS + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_SCANS);

    logic tick;

    scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .tick (tick)
    );

    scan_state_t      state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_drv_q, col_drv_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             overrun_q, overrun_d;
    logic [3:0]       digit_new_q, digit_new_d;
    logic [3:0]       digit_old_q, digit_old_d;

    row_hit_t         hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             cap_high;
    logic             accept;
    logic [3:0]       accept_code;
    logic             handshake;

    // Scan FSM: everything advances only on tick cycles.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        accept_code = KEY_MAP[{col_idx_q, row_idx_q}];
        hit         = onehot_row_idx(row_d);
        cnt_inc     = cnt_q + 1'b1;
        cap_high    = row_d[row_idx_q];

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit.valid) begin
                        row_idx_d = hit.idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = KEY_MAP[{col_idx_q, hit.idx}];
                            state_d     = HELD;
                            cnt_d       = '0;
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_d == (4'b0001 << row_idx_q)) begin
                        if (cnt_inc == DEB_LAST) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end
                end
                HELD: begin
                    // Only the captured row matters; other rows are locked out.
                    if (!cap_high) begin
                        if (RELEASE_SCANS == 1) begin
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                            cnt_d     = '0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (!cap_high) begin
                        if (cnt_inc == REL_LAST) begin
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end

        col_drv_d = 4'b0001 << col_idx_d;
    end

    // Output register: a consume in the same cycle as an accept frees the
    // slot, so the new key is loaded instead of being dropped.
    always_comb begin
        handshake   = key_valid_q & kif.key_ready;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = 1'b0;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        if (handshake) begin
            key_valid_d = 1'b0;
            digit_new_d = key_code_q;
            digit_old_d = digit_new_q;
        end

        if (accept) begin
            if (!key_valid_q || handshake) begin
                key_code_d  = accept_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            col_drv_q   <= 4'b0001;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            digit_new_q <= 4'd0;
            digit_old_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_drv_q   <= col_drv_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    assign col_q         = col_drv_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.overrun   = overrun_q;
    assign digit_new     = digit_new_q;
    assign digit_old     = digit_old_q;

endmodule
